// File: rtl/sum_accumulator_19bit_if.sv
// Handshake bundle between the 18-bit adder result stream and the block accumulator.
interface sum_accumulator_19bit_if #(
    parameter int ACC_W = 22,
    parameter int CNT_W = 8
);
    logic [18:0]      sum_in;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] sample_cnt;
    logic             ovf;

    modport master (
        output sum_in, in_valid, flush, out_ready,
        input  in_ready, acc_out, out_valid, sample_cnt, ovf
    );

    modport slave (
        input  sum_in, in_valid, flush, out_ready,
        output in_ready, acc_out, out_valid, sample_cnt, ovf
    );
endinterface

// File: rtl/sum_accumulator_19bit.sv
// Accumulates N_SAMPLES adder results per block and presents the registered total.
// Define SUM_ACC_SATURATE_EN to saturate additions at 2^ACC_W-1 and drive a sticky ovf.
module sum_accumulator_19bit #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 22,
    parameter int CNT_W     = 8
) (
    input logic clk,
    input logic rst,
    sum_accumulator_19bit_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic [CNT_W-1:0] sample_cnt;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] sum_next;
    logic             last;

    assign sum_ext = ACC_W'(bus.sum_in);
    assign last    = (sample_cnt == CNT_W'(N_SAMPLES - 1));

`ifdef SUM_ACC_SATURATE_EN
    logic [ACC_W:0] sum_wide;
    logic           sat;
    logic           ovf;

    // One extra bit catches the carry out of the accumulator width.
    assign sum_wide = {1'b0, acc} + {1'b0, sum_ext};
    assign sat      = sum_wide[ACC_W];
    assign sum_next = sat ? '1 : sum_wide[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == ACCUM && !bus.flush && bus.in_valid && sat)
            ovf <= 1'b1;
    end

    assign bus.ovf = ovf;
`else
    assign sum_next = acc + sum_ext;
    assign bus.ovf  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            sample_cnt <= '0;
            acc_out    <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    // flush wins over a sample presented in the same cycle
                    if (bus.flush) begin
                        acc        <= '0;
                        sample_cnt <= '0;
                    end else if (bus.in_valid) begin
                        if (last) begin
                            acc_out    <= sum_next;
                            out_valid  <= 1'b1;
                            acc        <= '0;
                            sample_cnt <= '0;
                            state      <= HOLD;
                        end else begin
                            acc        <= sum_next;
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready   = (state == ACCUM);
    assign bus.acc_out    = acc_out;
    assign bus.out_valid  = out_valid;
    assign bus.sample_cnt = sample_cnt;
endmodule

// File: tb/tb_sum_accumulator_19bit.sv
// Scoreboard bench: default 22-bit accumulator plus a 20-bit copy for the wrap/saturate case.
module tb_sum_accumulator_19bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] sum_in = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [21:0] model_acc = '0;
    int          model_cnt = 0;
    logic [21:0] exp_q[$];

    always #5 clk = ~clk;

    sum_accumulator_19bit_if #(.ACC_W(22), .CNT_W(8)) bus ();
    sum_accumulator_19bit_if #(.ACC_W(20), .CNT_W(8)) bus20 ();

    assign bus.sum_in      = sum_in;
    assign bus.in_valid    = in_valid;
    assign bus.flush       = flush;
    assign bus.out_ready   = out_ready;
    assign bus20.sum_in    = sum_in;
    assign bus20.in_valid  = in_valid;
    assign bus20.flush     = flush;
    assign bus20.out_ready = out_ready;

    sum_accumulator_19bit #(.N_SAMPLES(8), .ACC_W(22), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    sum_accumulator_19bit #(.N_SAMPLES(8), .ACC_W(20), .CNT_W(8)) dut20 (
        .clk(clk), .rst(rst), .bus(bus20)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present one sample and return #1 after the edge that accepts it.
    task automatic send(input logic [18:0] v);
        int t = 0;
        sum_in   = v;
        in_valid = 1'b1;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        model_acc = model_acc + 22'(v);
        model_cnt++;
        if (model_cnt == 8) begin
            exp_q.push_back(model_acc);
            model_acc = '0;
            model_cnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_out", 32'd1, 32'd0);
            else
                chk("acc_out", 32'(bus.acc_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #5 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_acc_out",    32'(bus.acc_out),    32'd0);
        chk("rst_sample_cnt", 32'(bus.sample_cnt), 32'd0);
        chk("rst_ovf",        32'(bus.ovf),        32'd0);

        // max-value sums, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(19'h7FFFF);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_in_ready",  32'(bus.in_ready),  32'd0);
        chk("t1_value",     32'(bus.acc_out),   32'h3FFFF8);
`ifdef SUM_ACC_SATURATE_EN
        chk("w20_acc_out", 32'(bus20.acc_out), 32'hFFFFF);
        chk("w20_ovf",     32'(bus20.ovf),     32'd1);
`else
        chk("w20_acc_out", 32'(bus20.acc_out), 32'hFFFF8);
        chk("w20_ovf",     32'(bus20.ovf),     32'd0);
`endif
        idle(1);
        chk("t1_valid_pulse", 32'(bus.out_valid), 32'd0);
        chk("t1_in_ready_back", 32'(bus.in_ready), 32'd1);

        // back-pressure: output held while out_ready is low
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(19'(i));
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_value", 32'(bus.acc_out),   32'd36);
            chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_hold_ready", 32'(bus.in_ready),  32'd0);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        chk("t2_in_ready_after", 32'(bus.in_ready),  32'd1);
        chk("t2_valid_after",    32'(bus.out_valid), 32'd0);

        // flush with a simultaneous sample
        for (int i = 0; i < 3; i++) send(19'd100);
        chk("t3_cnt_pre", 32'(bus.sample_cnt), 32'd3);
        sum_in = 19'd50; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        model_acc = '0; model_cnt = 0;
        chk("t3_cnt_flush", 32'(bus.sample_cnt), 32'd0);
        for (int i = 0; i < 8; i++) send(19'd1);
        idle(1);

        // bubbles between samples
        for (int i = 0; i < 8; i++) begin
            send(19'd10);
            chk("t4_cnt", 32'(bus.sample_cnt), 32'(model_cnt));
            idle(1);
            chk("t4_cnt_bubble", 32'(bus.sample_cnt), 32'(model_cnt));
        end

        // async reset mid-block, acc_out still holds the previous total
        for (int i = 0; i < 5; i++) send(19'd3);
        chk("t5_acc_out_pre", 32'(bus.acc_out), 32'd80);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_acc_out", 32'(bus.acc_out),    32'd0);
        chk("t5_rst_valid",   32'(bus.out_valid),  32'd0);
        chk("t5_rst_cnt",     32'(bus.sample_cnt), 32'd0);
        #2 rst = 1'b0;
        model_acc = '0; model_cnt = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send(19'd2);
        idle(2);

        chk("ovf_main", 32'(bus.ovf), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
